// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single cache-to-memory request port between the icache refill
// read port, the dcache load-miss read port and the dcache store port.
// Grants are round-robin, reads carry a TID from a 2**TidWidth pool, stores
// in flight are capped, and responses are routed back to their issuer.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rd_req_*                two read request ports ([0] icache, [1] dcache)
//   st_req_*                store request port
//   mem_req_*               registered request slot toward memory
//   mem_rsp_*               responses from memory (no backpressure)
//   rd_rsp_valid_o/rdata_o  read response routed to the owning port
//   st_ack_o                store acknowledgement
//   outstanding_stores_o    in-flight store count
//   idle_o, error_o         idle status, sticky protocol error
module mem_port_arbiter #(
    parameter int unsigned AddrWidth            = 64,
    parameter int unsigned DataWidth            = 64,
    parameter int unsigned TidWidth             = 2,
    parameter int unsigned MaxOutstandingStores = 7
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [1:0]                                  rd_req_valid_i,
    output logic [1:0]                                  rd_req_ready_o,
    input  logic [2*AddrWidth-1:0]                      rd_req_addr_i,
    input  logic                                        st_req_valid_i,
    output logic                                        st_req_ready_o,
    input  logic [AddrWidth-1:0]                        st_req_addr_i,
    input  logic [DataWidth-1:0]                        st_req_wdata_i,
    input  logic [DataWidth/8-1:0]                      st_req_be_i,
    output logic                                        mem_req_valid_o,
    input  logic                                        mem_req_ready_i,
    output logic                                        mem_req_we_o,
    output logic [AddrWidth-1:0]                        mem_req_addr_o,
    output logic [DataWidth-1:0]                        mem_req_wdata_o,
    output logic [DataWidth/8-1:0]                      mem_req_be_o,
    output logic [TidWidth-1:0]                         mem_req_tid_o,
    input  logic                                        mem_rsp_valid_i,
    input  logic                                        mem_rsp_we_i,
    input  logic [TidWidth-1:0]                         mem_rsp_tid_i,
    input  logic [DataWidth-1:0]                        mem_rsp_rdata_i,
    output logic [1:0]                                  rd_rsp_valid_o,
    output logic [DataWidth-1:0]                        rd_rsp_rdata_o,
    output logic                                        st_ack_o,
    output logic [$clog2(MaxOutstandingStores+1)-1:0]   outstanding_stores_o,
    output logic                                        idle_o,
    output logic                                        error_o
);

    localparam int unsigned NumTid   = 1 << TidWidth;
    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned CntWidth = $clog2(MaxOutstandingStores + 1);

    // Request slot
    logic                 r_req_valid;
    logic                 r_req_we;
    logic [AddrWidth-1:0] r_req_addr;
    logic [DataWidth-1:0] r_req_wdata;
    logic [BeWidth-1:0]   r_req_be;
    logic [TidWidth-1:0]  r_req_tid;

    // Arbitration / bookkeeping state
    logic [1:0]           r_rr_ptr;
    logic [NumTid-1:0]    r_tid_busy;
    logic [NumTid-1:0]    r_tid_owner;
    logic [CntWidth-1:0]  r_st_cnt;
    logic                 r_error;

    logic                 w_slot_free;
    logic                 w_tid_avail;
    logic [TidWidth-1:0]  w_free_tid;
    logic [2:0]           w_elig;
    logic [2:0]           w_sum;
    logic [1:0]           w_idx;
    logic                 w_any;
    logic [1:0]           w_win;
    logic                 w_st_acc;
    logic [AddrWidth-1:0] w_rd_addr;
    logic                 w_rd_ok;
    logic                 w_ack_ok;
    logic                 w_bad;

    assign w_slot_free = !r_req_valid || mem_req_ready_i;

    // Lowest-numbered free TID (descending scan so the lowest index wins)
    always_comb begin
        w_free_tid  = '0;
        w_tid_avail = 1'b0;
        for (int i = int'(NumTid) - 1; i >= 0; i--) begin
            if (!r_tid_busy[i]) begin
                w_free_tid  = TidWidth'(i);
                w_tid_avail = 1'b1;
            end
        end
    end

    assign w_elig[0] = rd_req_valid_i[0] && w_tid_avail;
    assign w_elig[1] = rd_req_valid_i[1] && w_tid_avail;
    assign w_elig[2] = st_req_valid_i && (r_st_cnt < CntWidth'(MaxOutstandingStores));

    // Round-robin pick over {rd0, rd1, st} starting at r_rr_ptr
    always_comb begin
        w_any = 1'b0;
        w_win = 2'd0;
        w_sum = 3'd0;
        w_idx = 2'd0;
        if (w_slot_free && !rst_i) begin
            for (int k = 0; k < 3; k++) begin
                w_sum = 3'(r_rr_ptr) + 3'(k);
                w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : 2'(w_sum);
                if (!w_any && w_elig[w_idx]) begin
                    w_any = 1'b1;
                    w_win = w_idx;
                end
            end
        end
    end

    assign rd_req_ready_o[0] = w_any && (w_win == 2'd0);
    assign rd_req_ready_o[1] = w_any && (w_win == 2'd1);
    assign st_req_ready_o    = w_any && (w_win == 2'd2);
    assign w_st_acc          = st_req_ready_o;
    assign w_rd_addr         = w_win[0] ? rd_req_addr_i[2*AddrWidth-1:AddrWidth]
                                        : rd_req_addr_i[AddrWidth-1:0];

    // Response routing and protocol checking
    assign w_rd_ok  = !rst_i && mem_rsp_valid_i && !mem_rsp_we_i && r_tid_busy[mem_rsp_tid_i];
    assign w_ack_ok = !rst_i && mem_rsp_valid_i && mem_rsp_we_i && (r_st_cnt != '0);
    assign w_bad    = !rst_i && mem_rsp_valid_i &&
                      ((!mem_rsp_we_i && !r_tid_busy[mem_rsp_tid_i]) ||
                       (mem_rsp_we_i && (r_st_cnt == '0)));

    assign rd_rsp_valid_o = !w_rd_ok ? 2'b00 :
                            (r_tid_owner[mem_rsp_tid_i] ? 2'b10 : 2'b01);
    assign rd_rsp_rdata_o = rst_i ? '0 : mem_rsp_rdata_i;
    assign st_ack_o       = w_ack_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_be    <= '0;
            r_req_tid   <= '0;
            r_rr_ptr    <= 2'd0;
            r_tid_busy  <= '0;
            r_tid_owner <= '0;
            r_st_cnt    <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_any) begin
                r_req_valid <= 1'b1;
                r_rr_ptr    <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
                if (w_win == 2'd2) begin
                    r_req_we    <= 1'b1;
                    r_req_addr  <= st_req_addr_i;
                    r_req_wdata <= st_req_wdata_i;
                    r_req_be    <= st_req_be_i;
                    r_req_tid   <= '0;
                end else begin
                    r_req_we                 <= 1'b0;
                    r_req_addr               <= w_rd_addr;
                    r_req_wdata              <= '0;
                    r_req_be                 <= '1;
                    r_req_tid                <= w_free_tid;
                    r_tid_busy[w_free_tid]   <= 1'b1;
                    r_tid_owner[w_free_tid]  <= w_win[0];
                end
            end else if (w_slot_free) begin
                r_req_valid <= 1'b0;
            end

            // Freed TID is busy in registered state, so it never equals w_free_tid
            if (w_rd_ok) begin
                r_tid_busy[mem_rsp_tid_i] <= 1'b0;
            end

            case ({w_st_acc, w_ack_ok})
                2'b10:   r_st_cnt <= r_st_cnt + CntWidth'(1);
                2'b01:   r_st_cnt <= r_st_cnt - CntWidth'(1);
                default: r_st_cnt <= r_st_cnt;
            endcase

            if (w_bad) begin
                r_error <= 1'b1;
            end
        end
    end

    assign mem_req_valid_o      = r_req_valid;
    assign mem_req_we_o         = r_req_we;
    assign mem_req_addr_o       = r_req_addr;
    assign mem_req_wdata_o      = r_req_wdata;
    assign mem_req_be_o         = r_req_be;
    assign mem_req_tid_o        = r_req_tid;
    assign outstanding_stores_o = r_st_cnt;
    assign idle_o               = !r_req_valid && (r_tid_busy == '0) && (r_st_cnt == '0);
    assign error_o              = r_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by a randomized phase; every cycle the DUT is
// compared against a transaction-level reference model (TID owner table,
// store counter, round-robin pointer, held request).
module tb_mem_port_arbiter;

    localparam int MAXST = 7;

    logic         clk;
    logic         rst_i;
    logic [1:0]   rd_req_valid_i;
    logic [1:0]   rd_req_ready_o;
    logic [127:0] rd_req_addr_i;
    logic         st_req_valid_i;
    logic         st_req_ready_o;
    logic [63:0]  st_req_addr_i;
    logic [63:0]  st_req_wdata_i;
    logic [7:0]   st_req_be_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic         mem_req_we_o;
    logic [63:0]  mem_req_addr_o;
    logic [63:0]  mem_req_wdata_o;
    logic [7:0]   mem_req_be_o;
    logic [1:0]   mem_req_tid_o;
    logic         mem_rsp_valid_i;
    logic         mem_rsp_we_i;
    logic [1:0]   mem_rsp_tid_i;
    logic [63:0]  mem_rsp_rdata_i;
    logic [1:0]   rd_rsp_valid_o;
    logic [63:0]  rd_rsp_rdata_o;
    logic         st_ack_o;
    logic [2:0]   outstanding_stores_o;
    logic         idle_o;
    logic         error_o;

    mem_port_arbiter dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .rd_req_valid_i       (rd_req_valid_i),
        .rd_req_ready_o       (rd_req_ready_o),
        .rd_req_addr_i        (rd_req_addr_i),
        .st_req_valid_i       (st_req_valid_i),
        .st_req_ready_o       (st_req_ready_o),
        .st_req_addr_i        (st_req_addr_i),
        .st_req_wdata_i       (st_req_wdata_i),
        .st_req_be_i          (st_req_be_i),
        .mem_req_valid_o      (mem_req_valid_o),
        .mem_req_ready_i      (mem_req_ready_i),
        .mem_req_we_o         (mem_req_we_o),
        .mem_req_addr_o       (mem_req_addr_o),
        .mem_req_wdata_o      (mem_req_wdata_o),
        .mem_req_be_o         (mem_req_be_o),
        .mem_req_tid_o        (mem_req_tid_o),
        .mem_rsp_valid_i      (mem_rsp_valid_i),
        .mem_rsp_we_i         (mem_rsp_we_i),
        .mem_rsp_tid_i        (mem_rsp_tid_i),
        .mem_rsp_rdata_i      (mem_rsp_rdata_i),
        .rd_rsp_valid_o       (rd_rsp_valid_o),
        .rd_rsp_rdata_o       (rd_rsp_rdata_o),
        .st_ack_o             (st_ack_o),
        .outstanding_stores_o (outstanding_stores_o),
        .idle_o               (idle_o),
        .error_o              (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_owner[4];   // -1 = free, else owning read port
    int          m_cnt;
    int          m_rr;
    bit          m_err;
    bit          m_valid;
    bit          m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_be;
    logic [1:0]  m_tid;
    logic [2:0]  obs_grant;    // DUT {st, rd1, rd0} readies seen this cycle

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_owner[i] = -1;
        m_cnt   = 0;
        m_rr    = 0;
        m_err   = 1'b0;
        m_valid = 1'b0;
    endtask

    function automatic bit model_idle();
        bit any_busy = 1'b0;
        for (int i = 0; i < 4; i++) if (m_owner[i] >= 0) any_busy = 1'b1;
        return !m_valid && !any_busy && (m_cnt == 0);
    endfunction

    task automatic clear_inputs();
        rd_req_valid_i  = 2'b00;
        st_req_valid_i  = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_we_i    = 1'b0;
        mem_rsp_tid_i   = 2'd0;
    endtask

    // One clock: compare at negedge, advance the model at posedge.
    task automatic cycle();
        int  ft;
        int  w;
        int  p;
        bit  slot_free;
        bit  el[3];
        logic [1:0] exp_rsp;
        bit  exp_ack;
        bit  bad;
        @(negedge clk);
        if (rst_i) model_reset();
        chk("mem_req_valid", 64'(mem_req_valid_o), 64'(m_valid));
        if (m_valid) begin
            chk("mem_req_we",    64'(mem_req_we_o), 64'(m_we));
            chk("mem_req_addr",  mem_req_addr_o, m_addr);
            chk("mem_req_wdata", mem_req_wdata_o, m_wdata);
            chk("mem_req_be",    64'(mem_req_be_o), 64'(m_be));
            chk("mem_req_tid",   64'(mem_req_tid_o), 64'(m_tid));
        end
        chk("outstanding", 64'(outstanding_stores_o), 64'(m_cnt));
        chk("idle",  64'(idle_o),  64'(model_idle()));
        chk("error", 64'(error_o), 64'(m_err));

        ft = -1;
        for (int i = 3; i >= 0; i--) if (m_owner[i] < 0) ft = i;
        slot_free = !m_valid || mem_req_ready_i;
        el[0] = rd_req_valid_i[0] && (ft >= 0);
        el[1] = rd_req_valid_i[1] && (ft >= 0);
        el[2] = st_req_valid_i && (m_cnt < MAXST);
        w = -1;
        if (!rst_i && slot_free) begin
            for (int k = 0; k < 3; k++) begin
                p = (m_rr + k) % 3;
                if (w < 0 && el[p]) w = p;
            end
        end
        obs_grant = {st_req_ready_o, rd_req_ready_o};
        chk("rd_req_ready", 64'(rd_req_ready_o), 64'({w == 1, w == 0}));
        chk("st_req_ready", 64'(st_req_ready_o), 64'(w == 2));

        exp_rsp = 2'b00;
        exp_ack = 1'b0;
        bad     = 1'b0;
        if (!rst_i && mem_rsp_valid_i) begin
            if (!mem_rsp_we_i) begin
                if (m_owner[mem_rsp_tid_i] >= 0) exp_rsp = 2'(1 << m_owner[mem_rsp_tid_i]);
                else bad = 1'b1;
            end else begin
                if (m_cnt > 0) exp_ack = 1'b1;
                else bad = 1'b1;
            end
        end
        chk("rd_rsp_valid", 64'(rd_rsp_valid_o), 64'(exp_rsp));
        chk("st_ack", 64'(st_ack_o), 64'(exp_ack));
        if (exp_rsp != 2'b00) chk("rd_rsp_rdata", rd_rsp_rdata_o, mem_rsp_rdata_i);

        @(posedge clk);
        if (rst_i) begin
            model_reset();
        end else begin
            if (exp_rsp != 2'b00) m_owner[mem_rsp_tid_i] = -1;
            if (exp_ack) m_cnt--;
            if (bad) m_err = 1'b1;
            if (w >= 0) begin
                m_valid = 1'b1;
                m_rr    = (w + 1) % 3;
                if (w == 2) begin
                    m_we    = 1'b1;
                    m_addr  = st_req_addr_i;
                    m_wdata = st_req_wdata_i;
                    m_be    = st_req_be_i;
                    m_tid   = 2'd0;
                    m_cnt++;
                end else begin
                    m_we    = 1'b0;
                    m_addr  = (w == 1) ? rd_req_addr_i[127:64] : rd_req_addr_i[63:0];
                    m_wdata = 64'd0;
                    m_be    = 8'hFF;
                    m_tid   = 2'(ft);
                    m_owner[ft] = w;
                end
            end else if (slot_free) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        mem_req_ready_i = 1'b1;
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        int acc;
        int busy_q[$];
        logic [63:0] held_addr;

        clear_inputs();
        rd_req_addr_i   = '0;
        st_req_addr_i   = '0;
        st_req_wdata_i  = '0;
        st_req_be_i     = '0;
        mem_rsp_rdata_i = '0;
        mem_req_ready_i = 1'b1;
        rst_i           = 1'b1;
        model_reset();

        // Reset values
        cycle();
        cycle();
        chk("reset_valid", 64'(mem_req_valid_o), 64'd0);
        chk("reset_idle",  64'(idle_o), 64'd1);
        rst_i = 1'b0;

        // Single read on rd0 and its response
        rd_req_valid_i = 2'b01;
        rd_req_addr_i  = {64'h0, 64'h1000};
        cycle();
        clear_inputs();
        chk("rd0_valid", 64'(mem_req_valid_o), 64'd1);
        chk("rd0_tid",   64'(mem_req_tid_o), 64'd0);
        chk("rd0_be",    64'(mem_req_be_o), 64'hFF);
        cycle();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_tid_i   = 2'd0;
        mem_rsp_rdata_i = 64'hDEAD;
        cycle();
        chk("rd0_rsp_port", 64'(obs_grant), 64'd0);
        clear_inputs();
        cycle();
        chk("rd0_idle_after", 64'(idle_o), 64'd1);

        // All three ports continuously valid: rotation rd0, rd1, st, rd0
        do_reset();
        rd_req_valid_i = 2'b11;
        rd_req_addr_i  = {64'h2000, 64'h3000};
        st_req_valid_i = 1'b1;
        st_req_addr_i  = 64'h4000;
        st_req_wdata_i = 64'h1234_5678;
        st_req_be_i    = 8'h0F;
        cycle(); chk("rot0", 64'(obs_grant), 64'b001);
        cycle(); chk("rot1", 64'(obs_grant), 64'b010);
        cycle(); chk("rot2", 64'(obs_grant), 64'b100);
        cycle(); chk("rot3", 64'(obs_grant), 64'b001);
        chk("rot3_tid", 64'(mem_req_tid_o), 64'd2);
        clear_inputs();
        cycle();

        // TID exhaustion: four reads accepted, fifth stalls until a TID frees
        do_reset();
        rd_req_valid_i = 2'b01;
        acc = 0;
        for (int n = 0; n < 5; n++) begin
            rd_req_addr_i = {64'h0, 64'(32'h100 * n)};
            cycle();
            if (obs_grant == 3'b001) acc++;
        end
        chk("tid_exhaust_acc", 64'(acc), 64'd4);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_tid_i   = 2'd2;
        mem_rsp_rdata_i = 64'hBEEF;
        cycle();
        chk("freed_same_cycle_stall", 64'(obs_grant), 64'd0);
        mem_rsp_valid_i = 1'b0;
        cycle();
        chk("freed_next_cycle_acc", 64'(obs_grant), 64'b001);
        chk("freed_tid_reused", 64'(mem_req_tid_o), 64'd2);
        clear_inputs();
        cycle();

        // Store cap: seven accepted, eighth stalls, one ack lets it through
        do_reset();
        st_req_valid_i = 1'b1;
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            st_req_addr_i  = 64'(32'h8000 + 8 * n);
            st_req_wdata_i = {$urandom, $urandom};
            cycle();
            if (obs_grant == 3'b100) acc++;
        end
        chk("store_cap_acc", 64'(acc), 64'd7);
        chk("store_cap_cnt", 64'(outstanding_stores_o), 64'd7);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_we_i    = 1'b1;
        cycle();
        chk("ack_same_cycle_stall", 64'(obs_grant), 64'd0);
        mem_rsp_valid_i = 1'b0;
        mem_rsp_we_i    = 1'b0;
        cycle();
        chk("ack_next_cycle_acc", 64'(obs_grant), 64'b100);
        chk("store_cnt_back_7", 64'(outstanding_stores_o), 64'd7);
        clear_inputs();
        cycle();

        // Backpressure: request held stable while ready is low
        do_reset();
        rd_req_valid_i = 2'b01;
        rd_req_addr_i  = {64'h0, 64'hA000};
        cycle();
        held_addr = mem_req_addr_o;
        mem_req_ready_i = 1'b0;
        rd_req_valid_i  = 2'b10;
        rd_req_addr_i   = {64'hB000, 64'h0};
        st_req_valid_i  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("stall_no_grant", 64'(obs_grant), 64'd0);
            chk("stall_addr_stable", mem_req_addr_o, held_addr);
        end
        mem_req_ready_i = 1'b1;
        cycle();
        chk("stall_release_rd1", 64'(obs_grant), 64'b010);
        clear_inputs();
        cycle();
        cycle();

        // Protocol errors are sticky until reset
        do_reset();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_tid_i   = 2'd1;
        cycle();
        chk("err_after_bad_read", 64'(error_o), 64'd1);
        mem_rsp_we_i = 1'b1;
        cycle();
        clear_inputs();
        cycle();
        cycle();
        chk("err_sticky", 64'(error_o), 64'd1);
        do_reset();
        chk("err_cleared", 64'(error_o), 64'd0);

        // Reset mid-operation drops state; stale response flags an error
        rd_req_valid_i = 2'b01;
        st_req_valid_i = 1'b1;
        cycle();
        cycle();
        do_reset();
        chk("midreset_idle", 64'(idle_o), 64'd1);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_tid_i   = 2'd0;
        cycle();
        clear_inputs();
        cycle();
        chk("midreset_stale_err", 64'(error_o), 64'd1);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            rd_req_valid_i  = 2'($urandom_range(0, 3));
            rd_req_addr_i   = {$urandom, $urandom, $urandom, $urandom};
            st_req_valid_i  = ($urandom_range(0, 2) != 0);
            st_req_addr_i   = {$urandom, $urandom};
            st_req_wdata_i  = {$urandom, $urandom};
            st_req_be_i     = 8'($urandom);
            mem_req_ready_i = ($urandom_range(0, 3) != 0);
            mem_rsp_valid_i = 1'b0;
            mem_rsp_we_i    = 1'b0;
            mem_rsp_tid_i   = 2'd0;
            mem_rsp_rdata_i = {$urandom, $urandom};
            busy_q.delete();
            for (int i = 0; i < 4; i++) if (m_owner[i] >= 0) busy_q.push_back(i);
            r = $urandom_range(0, 9);
            if (r < 4 && busy_q.size() > 0) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_tid_i   = 2'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
            end else if (r < 7 && m_cnt > 0) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_we_i    = 1'b1;
            end else if (r == 9 && $urandom_range(0, 31) == 0) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_we_i    = 1'($urandom);
                mem_rsp_tid_i   = 2'($urandom);
            end
            rst_i = (n % 300 == 299);
            cycle();
        end
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
